urv_gpio_bank: RTL and testbench
================================

URV_GPIO_BANK -- requirements
Module: urv_gpio_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of GPIO channels (legal 1..32).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h1000_0000, byte address of register 0.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth (legal 2..3).
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port dm_addr_i  input  32  CPU data-bus byte address.
REQ-007 SHALL have port dm_data_s_i  input  32  store data.
REQ-008 SHALL have port dm_data_select_i  input  4  byte lane enables for stores.
REQ-009 SHALL have port dm_store_i  input  1  store request, one cycle.
REQ-010 SHALL have port dm_load_i  input  1  load request, one cycle.
REQ-011 SHALL have port dm_data_l_o  output  32  load data, valid with dm_load_done_o.
REQ-012 SHALL have port dm_store_done_o  output  1  store completion pulse.
REQ-013 SHALL have port dm_load_done_o  output  1  load completion pulse.
REQ-014 SHALL have port sel_o  output  1  combinational: dm_addr_i[31:5] == BASE_ADDR[31:5].
REQ-015 SHALL have port gpio_i  input  NUM_CH  asynchronous pin inputs.
REQ-016 SHALL have port gpio_o  output  NUM_CH  pin outputs, driven directly from OUT register.
REQ-017 SHALL have port irq_o  output  1  level interrupt = |(IRQ_STAT & IRQ_EN), from registers only.

Function
REQ-018 SHALL decode word offset dm_addr_i[4:2]: 0 OUT (RW), 1 SET (WO), 2 CLR (WO), 3 TGL (WO), 4 IN (RO), 5 IRQ_EN (RW), 6 IRQ_STAT (W1C), 7 EDGE_CFG (RW; 0 = rising, 1 = falling).
REQ-019 SHALL commit a store on the edge where dm_store_i && sel_o, writing only bytes whose dm_data_select_i bit is 1.
REQ-020 SHALL apply SET as OUT |= masked data, CLR as OUT &= ~masked data, TGL as OUT ^= masked data, where masked data zeroes disabled lanes.
REQ-021 SHALL ignore data bits at or above NUM_CH on write and return 0 for them on read.
REQ-022 SHALL register load data on the edge where dm_load_i && sel_o; WO offsets (1..3) read 0.
REQ-023 SHALL pulse dm_store_done_o / dm_load_done_o high for exactly one cycle, the cycle after the accepted request (latency 1).
REQ-024 SHALL ignore dm_store_i/dm_load_i when sel_o is 0 (no done pulse, no state change).
REQ-025 SHALL synchronize gpio_i through SYNC_STAGES flops; IN reads the final stage.
REQ-026 SHALL detect an edge per channel by comparing final stage with one further delayed flop, polarity per EDGE_CFG bit, and set the IRQ_STAT bit on the following edge.
REQ-027 SHALL give edge-set priority over W1C when both hit the same IRQ_STAT bit in one cycle.
REQ-028 SHALL NOT generate a spurious edge when EDGE_CFG changes; detection uses the new polarity from the cycle after the write.
REQ-029 SHALL treat simultaneous dm_store_i and dm_load_i as store-then-load-of-old-value: both done pulses asserted, load returns pre-store contents.

Reset
REQ-030 SHALL on rst_i low clear OUT, IRQ_EN, IRQ_STAT, EDGE_CFG, all synchronizer and delay flops, dm_data_l_o, both done outputs, so gpio_o = 0 and irq_o = 0.
REQ-031 SHALL on reset mid-transaction drop the pending done pulse; no edge event SHALL be recorded in the first cycle after release.

Structure
REQ-032 SHALL place register offset constants (OFS_OUT..OFS_EDGE_CFG) and width constants in shared package urv_io_pkg.
REQ-033 SHALL implement synchronizer plus edge detector as one sub-module urv_gpio_sync, instantiated once, NUM_CH wide.

Verification
REQ-034 SHALL test: store 0xA5 lanes 4'b0001 to offset 0 -> gpio_o = 0xA5, dm_store_done_o one cycle later; load offset 0 returns 0x000000A5.
REQ-035 SHALL test: OUT = 0xF0, SET 0x0F, CLR 0x30, TGL 0x81 -> gpio_o = 0x4E.
REQ-036 SHALL test: EDGE_CFG = 0, IRQ_EN = 0x01, gpio_i[0] 0->1 -> IRQ_STAT[0] = 1 and irq_o high within SYNC_STAGES+2 cycles; W1C 0x01 -> irq_o low next cycle.
REQ-037 SHALL test: W1C to IRQ_STAT bit 3 in same cycle as a new bit-3 edge -> bit 3 remains 1.
REQ-038 SHALL test: NUM_CH = 12, store 0xFFFF_FFFF to OUT -> readback 0x0000_0FFF; store to 0x2000_0000 -> no done pulse, OUT unchanged.
REQ-039 SHALL test: assert rst_i low during a pending load -> all outputs 0, no done pulse after release.

Source files
------------

// File: rtl/urv_io_pkg.sv
// Shared constants for the URV GPIO bank: register map, bus widths and a
// byte-lane expansion helper used by the store path.
package urv_io_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OFS_W  = 3;
   localparam int unsigned LANES  = DATA_W / 8;

   localparam logic [OFS_W-1:0] OFS_OUT      = 3'd0;
   localparam logic [OFS_W-1:0] OFS_SET      = 3'd1;
   localparam logic [OFS_W-1:0] OFS_CLR      = 3'd2;
   localparam logic [OFS_W-1:0] OFS_TGL      = 3'd3;
   localparam logic [OFS_W-1:0] OFS_IN       = 3'd4;
   localparam logic [OFS_W-1:0] OFS_IRQ_EN   = 3'd5;
   localparam logic [OFS_W-1:0] OFS_IRQ_STAT = 3'd6;
   localparam logic [OFS_W-1:0] OFS_EDGE_CFG = 3'd7;

   // Expands one enable bit per byte lane into a full-width bit mask.
   function automatic logic [DATA_W-1:0] lane_mask(input logic [LANES-1:0] sel);
      logic [DATA_W-1:0] m;
      m = '0;
      for (int i = 0; i < LANES; i++) begin
         m[i*8 +: 8] = {8{sel[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/urv_gpio_bank_if.sv
// Data-bus bundle between the CPU side and the GPIO bank.
// Handshake: dm_store/dm_load are one-cycle requests taken only while sel is
// high; the matching done pulse is high for exactly the following cycle.
interface urv_gpio_bank_if;
   import urv_io_pkg::*;

   logic [DATA_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_data_s;
   logic [LANES-1:0]  dm_data_select;
   logic              dm_store;
   logic              dm_load;
   logic [DATA_W-1:0] dm_data_l;
   logic              dm_store_done;
   logic              dm_load_done;
   logic              sel;

   modport master (
      output dm_addr, dm_data_s, dm_data_select, dm_store, dm_load,
      input  dm_data_l, dm_store_done, dm_load_done, sel
   );

   modport slave (
      input  dm_addr, dm_data_s, dm_data_select, dm_store, dm_load,
      output dm_data_l, dm_store_done, dm_load_done, sel
   );

endinterface

// File: rtl/urv_gpio_sync.sv
// Pin input synchronizer plus per-channel edge detector; one event per
// qualifying transition of the synchronized level, polarity per edge_cfg bit.
module urv_gpio_sync #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] pins,
   input  logic [WIDTH-1:0] edge_cfg,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] edge_ev
);

   logic [WIDTH-1:0] stage [STAGES];
   logic [WIDTH-1:0] dly;
   logic             armed;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < STAGES; i++) stage[i] <= '0;
         dly   <= '0;
         armed <= 1'b0;
      end else begin
         stage[0] <= pins;
         for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
         dly   <= stage[STAGES-1];
         armed <= 1'b1;
      end
   end

   assign level = stage[STAGES-1];

   // Events come only from level transitions, so rewriting edge_cfg alone never fires.
   assign edge_ev = armed ? ((level & ~dly & ~edge_cfg) | (~level & dly & edge_cfg))
                          : '0;

endmodule

// File: rtl/urv_gpio_bank.sv
// Memory-mapped GPIO bank: eight word registers behind the CPU data bus,
// set/clear/toggle aliases for OUT, and edge-triggered level interrupt.
module urv_gpio_bank
   import urv_io_pkg::*;
#(
   parameter int unsigned NUM_CH      = 8,
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       dm_addr_i,
   input  logic [31:0]       dm_data_s_i,
   input  logic [3:0]        dm_data_select_i,
   input  logic              dm_store_i,
   input  logic              dm_load_i,
   output logic [31:0]       dm_data_l_o,
   output logic              dm_store_done_o,
   output logic              dm_load_done_o,
   output logic              sel_o,
   input  logic [NUM_CH-1:0] gpio_i,
   output logic [NUM_CH-1:0] gpio_o,
   output logic              irq_o
);

   logic [OFS_W-1:0]  ofs;
   logic              wr, rd;
   logic [DATA_W-1:0] lanes_w;
   logic [NUM_CH-1:0] wmask, mdata;
   logic [NUM_CH-1:0] out_q, en_q, stat_q, cfg_q;
   logic [NUM_CH-1:0] out_d, en_d, stat_d, cfg_d, w1c;
   logic [NUM_CH-1:0] level, edge_ev;
   logic [DATA_W-1:0] rdata;
   logic              unused_bits;

   assign sel_o   = (dm_addr_i[31:5] == BASE_ADDR[31:5]);
   assign ofs     = dm_addr_i[4:2];
   assign wr      = dm_store_i && sel_o;
   assign rd      = dm_load_i && sel_o;
   assign lanes_w = lane_mask(dm_data_select_i);
   assign wmask   = lanes_w[NUM_CH-1:0];
   assign mdata   = dm_data_s_i[NUM_CH-1:0] & wmask;

   assign unused_bits = ^{dm_addr_i[1:0], dm_data_s_i, lanes_w};

   urv_gpio_sync #(.WIDTH(NUM_CH), .STAGES(SYNC_STAGES)) u_sync (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .pins     (gpio_i),
      .edge_cfg (cfg_q),
      .level    (level),
      .edge_ev  (edge_ev)
   );

   always_comb begin
      out_d = out_q;
      en_d  = en_q;
      cfg_d = cfg_q;
      w1c   = '0;
      if (wr) begin
         case (ofs)
            OFS_OUT:      out_d = (out_q & ~wmask) | mdata;
            OFS_SET:      out_d = out_q | mdata;
            OFS_CLR:      out_d = out_q & ~mdata;
            OFS_TGL:      out_d = out_q ^ mdata;
            OFS_IRQ_EN:   en_d  = (en_q & ~wmask) | mdata;
            OFS_IRQ_STAT: w1c   = mdata;
            OFS_EDGE_CFG: cfg_d = (cfg_q & ~wmask) | mdata;
            default:      ;
         endcase
      end
      // A fresh edge wins over a simultaneous write-one-to-clear.
      stat_d = (stat_q & ~w1c) | edge_ev;
   end

   // Read mux sees pre-store register values, so store+load returns old data.
   always_comb begin
      rdata = '0;
      case (ofs)
         OFS_OUT:      rdata[NUM_CH-1:0] = out_q;
         OFS_IN:       rdata[NUM_CH-1:0] = level;
         OFS_IRQ_EN:   rdata[NUM_CH-1:0] = en_q;
         OFS_IRQ_STAT: rdata[NUM_CH-1:0] = stat_q;
         OFS_EDGE_CFG: rdata[NUM_CH-1:0] = cfg_q;
         default:      rdata = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         out_q           <= '0;
         en_q            <= '0;
         stat_q          <= '0;
         cfg_q           <= '0;
         dm_data_l_o     <= '0;
         dm_store_done_o <= 1'b0;
         dm_load_done_o  <= 1'b0;
      end else begin
         out_q           <= out_d;
         en_q            <= en_d;
         stat_q          <= stat_d;
         cfg_q           <= cfg_d;
         dm_store_done_o <= wr;
         dm_load_done_o  <= rd;
         if (rd) dm_data_l_o <= rdata;
      end
   end

   assign gpio_o = out_q;
   assign irq_o  = |(stat_q & en_q);

endmodule

// File: tb/tb_urv_gpio_bank.sv
// Randomized scoreboard bench for urv_gpio_bank against a register-level
// reference model of the GPIO bank kept in plain variables.
module tb_urv_gpio_bank;
   import urv_io_pkg::*;

   localparam int unsigned NUM_CH = 12;
   localparam int unsigned SYNC   = 2;
   localparam logic [31:0] BASE   = 32'h1000_0000;
   localparam logic [31:0] CHM    = 32'h0000_0FFF;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NUM_CH-1:0] gpio_in = '0;
   logic [NUM_CH-1:0] gpio_out;
   logic              irq;

   urv_gpio_bank_if bus ();

   urv_gpio_bank #(.NUM_CH(NUM_CH), .BASE_ADDR(BASE), .SYNC_STAGES(SYNC)) dut (
      .clk_i            (clk),
      .rst_i            (rst_n),
      .dm_addr_i        (bus.dm_addr),
      .dm_data_s_i      (bus.dm_data_s),
      .dm_data_select_i (bus.dm_data_select),
      .dm_store_i       (bus.dm_store),
      .dm_load_i        (bus.dm_load),
      .dm_data_l_o      (bus.dm_data_l),
      .dm_store_done_o  (bus.dm_store_done),
      .dm_load_done_o   (bus.dm_load_done),
      .sel_o            (bus.sel),
      .gpio_i           (gpio_in),
      .gpio_o           (gpio_out),
      .irq_o            (irq)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   logic [31:0] out_m, en_m, stat_m, cfg_m, pins_m;
   logic [63:0] exp_q[$];
   logic [31:0] st_q[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] model_read(input logic [2:0] ofs);
      case (ofs)
         3'd0:    return out_m;
         3'd4:    return pins_m;
         3'd5:    return en_m;
         3'd6:    return stat_m;
         3'd7:    return cfg_m;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_store(input logic [2:0] ofs, input logic [31:0] data,
                              input logic [3:0] lanes);
      logic [31:0] lm, m;
      lm = 32'h0;
      for (int i = 0; i < 4; i++) if (lanes[i]) lm = lm | (32'hFF << (8 * i));
      lm = lm & CHM;
      m  = data & lm;
      case (ofs)
         3'd0: out_m  = (out_m & ~lm) | m;
         3'd1: out_m  = out_m | m;
         3'd2: out_m  = out_m & ~m;
         3'd3: out_m  = out_m ^ m;
         3'd5: en_m   = (en_m & ~lm) | m;
         3'd6: stat_m = stat_m & ~m;
         3'd7: cfg_m  = (cfg_m & ~lm) | m;
         default: ;
      endcase
   endtask

   task automatic model_pins(input logic [31:0] p);
      logic [31:0] rise, fall;
      rise   = p & ~pins_m & CHM;
      fall   = ~p & pins_m & CHM;
      stat_m = stat_m | (rise & ~cfg_m) | (fall & cfg_m);
      pins_m = p & CHM;
   endtask

   task automatic model_reset();
      out_m = 0; en_m = 0; stat_m = 0; cfg_m = 0; pins_m = 0;
   endtask

   // ---------------- driver tasks (enter and leave 1 time unit after a rising edge) ----------------
   task automatic do_op(input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] lanes, input bit st, input bit ld);
      bit hit;
      hit = (addr[31:5] == BASE[31:5]);
      if (hit && ld) exp_q.push_back({cyc + 32'd1, model_read(addr[4:2])});
      if (hit && st) begin
         st_q.push_back(cyc + 32'd1);
         model_store(addr[4:2], data, lanes);
      end
      bus.dm_addr = addr; bus.dm_data_s = data; bus.dm_data_select = lanes;
      bus.dm_store = st;  bus.dm_load = ld;
      #1;
      check("sel_o", {31'b0, bus.sel}, {31'b0, hit});
      @(posedge clk); #1;
      bus.dm_store = 1'b0; bus.dm_load = 1'b0;
   endtask

   task automatic wr(input logic [2:0] ofs, input logic [31:0] data, input logic [3:0] lanes);
      do_op(BASE | {27'b0, ofs, 2'b00}, data, lanes, 1'b1, 1'b0);
   endtask

   task automatic rd(input logic [2:0] ofs);
      do_op(BASE | {27'b0, ofs, 2'b00}, 32'h0, 4'h0, 1'b0, 1'b1);
   endtask

   task automatic set_pins(input logic [31:0] p);
      model_pins(p);
      gpio_in = p[NUM_CH-1:0];
      repeat (SYNC + 3) @(posedge clk);
      #1;
   endtask

   task automatic check_pins(input string name);
      check({name, "_gpio"}, {20'b0, gpio_out}, out_m & CHM);
      check({name, "_irq"}, {31'b0, irq}, {31'b0, |(stat_m & en_m)});
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic [63:0] mon_e;
   logic [31:0] mon_s;
   bit          st_due, ld_due;

   always @(negedge clk) begin
      st_due = (st_q.size() != 0) && (st_q[0] == cyc);
      if (bus.dm_store_done || st_due) begin
         check("store_done", {31'b0, bus.dm_store_done}, {31'b0, st_due});
         if (st_due) mon_s = st_q.pop_front();
      end
      ld_due = (exp_q.size() != 0) && (exp_q[0][63:32] == cyc);
      if (bus.dm_load_done || ld_due) begin
         check("load_done", {31'b0, bus.dm_load_done}, {31'b0, ld_due});
         if (ld_due) begin
            mon_e = exp_q.pop_front();
            check("load_data", bus.dm_data_l, mon_e[31:0]);
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [31:0] r_data, r_addr;
   logic [2:0]  r_ofs;
   logic [3:0]  r_lanes;
   bit          got;

   initial begin
      bus.dm_addr = '0; bus.dm_data_s = '0; bus.dm_data_select = '0;
      bus.dm_store = 1'b0; bus.dm_load = 1'b0;
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      check("rst_gpio", {20'b0, gpio_out}, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      check("rst_data_l", bus.dm_data_l, 32'h0);
      check("rst_dones", {30'b0, bus.dm_store_done, bus.dm_load_done}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Byte-lane store and readback
      wr(OFS_OUT, 32'hDEAD_BEA5, 4'b0001);
      check("gpio_a5", {20'b0, gpio_out}, 32'h0000_00A5);
      rd(OFS_OUT);

      // SET/CLR/TGL aliases
      wr(OFS_OUT, 32'h0000_00F0, 4'hF);
      wr(OFS_SET, 32'h0000_000F, 4'hF);
      wr(OFS_CLR, 32'h0000_0030, 4'hF);
      wr(OFS_TGL, 32'h0000_0081, 4'hF);
      check("gpio_4e", {20'b0, gpio_out}, 32'h0000_004E);
      rd(OFS_SET);

      // Channel width masking and unselected address
      wr(OFS_OUT, 32'hFFFF_FFFF, 4'hF);
      rd(OFS_OUT);
      do_op(32'h2000_0000, 32'h0000_0000, 4'hF, 1'b1, 1'b0);
      do_op(BASE + 32'h20, 32'h0000_0000, 4'hF, 1'b1, 1'b1);
      rd(OFS_OUT);
      check("gpio_fff", {20'b0, gpio_out}, 32'h0000_0FFF);

      // Rising edge on channel 0 raises irq within SYNC+2 cycles, W1C drops it
      wr(OFS_EDGE_CFG, 32'h0, 4'hF);
      wr(OFS_IRQ_EN, 32'h1, 4'hF);
      model_pins(pins_m | 32'h1);
      gpio_in = pins_m[NUM_CH-1:0];
      got = 1'b0;
      for (int i = 0; i < SYNC + 2 && !got; i++) begin
         @(posedge clk); #1;
         if (irq) got = 1'b1;
      end
      check("irq_rise", {31'b0, irq}, 32'h1);
      rd(OFS_IRQ_STAT);
      wr(OFS_IRQ_STAT, 32'h1, 4'b0001);
      check("irq_clear", {31'b0, irq}, 32'h0);

      // Edge beats W1C on the same bit in the same cycle
      set_pins(pins_m | 32'h8);
      set_pins(pins_m & ~32'h8);
      rd(OFS_IRQ_STAT);
      gpio_in = gpio_in | 12'h008;
      repeat (SYNC) @(posedge clk);
      #1;
      wr(OFS_IRQ_STAT, 32'h8, 4'b0001);
      model_pins(pins_m | 32'h8);
      repeat (3) @(posedge clk);
      #1;
      rd(OFS_IRQ_STAT);

      // Changing polarity on steady pins must not raise events
      wr(OFS_IRQ_STAT, 32'hFFFF_FFFF, 4'hF);
      wr(OFS_EDGE_CFG, 32'h0000_0FFF, 4'hF);
      repeat (3) @(posedge clk);
      #1;
      rd(OFS_IRQ_STAT);
      rd(OFS_IN);

      // Randomized traffic
      repeat (300) begin
         r_ofs   = 3'($urandom_range(0, 7));
         r_data  = $urandom;
         r_lanes = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 9))
            0, 1, 2, 3: wr(r_ofs, r_data, r_lanes);
            4, 5:       rd(r_ofs);
            6:          do_op(BASE | {27'b0, r_ofs, 2'b00}, r_data, r_lanes, 1'b1, 1'b1);
            7: begin
               r_addr = ($urandom_range(0, 1) == 0) ? 32'h2000_0000 : BASE + 32'h20;
               do_op(r_addr | {27'b0, r_ofs, 2'b00}, r_data, r_lanes,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            8:          set_pins($urandom & CHM);
            default:    check_pins("rand");
         endcase
      end
      check_pins("post_rand");

      // Reset while a load completion is pending
      wr(OFS_OUT, 32'h0000_05A5, 4'hF);
      wr(OFS_IRQ_EN, 32'h0000_0FFF, 4'hF);
      rd(OFS_OUT);
      repeat (2) @(posedge clk);
      #1;
      bus.dm_addr = BASE; bus.dm_load = 1'b1;
      @(posedge clk); #1;
      bus.dm_load = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_mid_gpio", {20'b0, gpio_out}, 32'h0);
      check("rst_mid_irq", {31'b0, irq}, 32'h0);
      check("rst_mid_data_l", bus.dm_data_l, 32'h0);
      check("rst_mid_dones", {30'b0, bus.dm_store_done, bus.dm_load_done}, 32'h0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_pins({20'b0, gpio_in});
      repeat (6) @(posedge clk);
      #1;
      check_pins("post_rst");
      rd(OFS_IRQ_STAT);
      rd(OFS_OUT);

      repeat (4) @(posedge clk);
      #1;
      check("queues_drained", exp_q.size() + st_q.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
